// File: rtl/dram_pkg.sv
// Shared definitions for the data RAM controller: funct3 codes, FSM state, debug view.
// Optional feature macro: DRAM_MISALIGN_TRAP_EN (see data_ram_ctrl.sv).
package dram_pkg;

    localparam int DRAM_ADDR_W = 6;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_SETUP,
        S_WR_STROBE,
        S_WR_HOLD,
        S_RESP
    } dram_state_t;

    typedef struct packed {
        dram_state_t state;
        logic        lane_drv;
    } dram_dbg_t;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic r;
        case (f3)
            F3_H, F3_HU: r = a[0];
            F3_W:        r = (a != 2'b00);
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_ram_ctrl_if.sv
// Memory-stage request/response bus between the pipeline (master) and the controller (slave).
// Handshake: a request transfers on a rising edge where req_valid && req_ready; rsp_valid is a one-cycle pulse.
interface data_ram_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dram_lane_align.sv
// Combinational lane address/alias generation, store byte steering and load extension.
module dram_lane_align
    import dram_pkg::*;
#(
    parameter int ADDR_W = DRAM_ADDR_W
) (
    input  logic [ADDR_W-1:0]      i_addr,
    input  logic [2:0]             i_funct3,
    input  logic [31:0]            i_wdata,
    output logic [3:0][ADDR_W-1:0] o_lane_addr,
    output logic [3:0][7:0]        o_lane_wdata,
    input  logic [2:0]             i_rd_funct3,
    input  logic [3:0][7:0]        i_rd_lane,
    output logic [31:0]            o_rdata
);

    // Inactive lanes repeat an active lane's address and byte, so a four-lane write is safe.
    always_comb begin
        o_lane_addr  = '0;
        o_lane_wdata = '0;
        case (i_funct3)
            F3_B, F3_BU: begin
                for (int i = 0; i < 4; i++) begin
                    o_lane_addr[i]  = i_addr;
                    o_lane_wdata[i] = i_wdata[7:0];
                end
            end
            F3_H, F3_HU: begin
                o_lane_addr[0]  = i_addr;
                o_lane_addr[1]  = i_addr + ADDR_W'(1);
                o_lane_addr[2]  = i_addr;
                o_lane_addr[3]  = i_addr + ADDR_W'(1);
                o_lane_wdata[0] = i_wdata[7:0];
                o_lane_wdata[1] = i_wdata[15:8];
                o_lane_wdata[2] = i_wdata[7:0];
                o_lane_wdata[3] = i_wdata[15:8];
            end
            default: begin
                for (int i = 0; i < 4; i++) begin
                    o_lane_addr[i]  = i_addr + ADDR_W'(i);
                    o_lane_wdata[i] = i_wdata[8*i +: 8];
                end
            end
        endcase
    end

    always_comb begin
        o_rdata = '0;
        case (i_rd_funct3)
            F3_B:    o_rdata = {{24{i_rd_lane[0][7]}}, i_rd_lane[0]};
            F3_BU:   o_rdata = {24'h0, i_rd_lane[0]};
            F3_H:    o_rdata = {{16{i_rd_lane[1][7]}}, i_rd_lane[1], i_rd_lane[0]};
            F3_HU:   o_rdata = {16'h0, i_rd_lane[1], i_rd_lane[0]};
            default: o_rdata = {i_rd_lane[3], i_rd_lane[2], i_rd_lane[1], i_rd_lane[0]};
        endcase
    end

endmodule

// File: rtl/data_ram_ctrl.sv
// Load/store sequencer for the four-lane byte-addressed data RAM.
// Define DRAM_MISALIGN_TRAP_EN to reject misaligned H/HU/W accesses with rsp_err.
module data_ram_ctrl
    import dram_pkg::*;
#(
    parameter int ADDR_W = DRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    data_ram_ctrl_if.slave    bus,
    output logic              ram_re,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr0,
    output logic [ADDR_W-1:0] ram_addr1,
    output logic [ADDR_W-1:0] ram_addr2,
    output logic [ADDR_W-1:0] ram_addr3,
    inout  wire  [7:0]        ram_data0,
    inout  wire  [7:0]        ram_data1,
    inout  wire  [7:0]        ram_data2,
    inout  wire  [7:0]        ram_data3,
    output dram_dbg_t         o_dbg
);

    dram_state_t             r_state;
    logic                    r_ready;
    logic                    r_rsp_valid;
    logic [31:0]             r_rdata;
    logic                    r_err;
    logic                    r_re;
    logic                    r_we;
    logic                    r_drv;
    logic [2:0]              r_funct3;
    logic [3:0][ADDR_W-1:0]  r_lane_addr;
    logic [3:0][7:0]         r_lane_wdata;

    logic [3:0][ADDR_W-1:0]  w_lane_addr;
    logic [3:0][7:0]         w_lane_wdata;
    logic [3:0][7:0]         w_rd_lane;
    logic [31:0]             w_rdata;
    logic                    w_reject;

    dram_lane_align #(.ADDR_W(ADDR_W)) u_align (
        .i_addr       (bus.req_addr[ADDR_W-1:0]),
        .i_funct3     (bus.req_funct3),
        .i_wdata      (bus.req_wdata),
        .o_lane_addr  (w_lane_addr),
        .o_lane_wdata (w_lane_wdata),
        .i_rd_funct3  (r_funct3),
        .i_rd_lane    (w_rd_lane),
        .o_rdata      (w_rdata)
    );

`ifdef DRAM_MISALIGN_TRAP_EN
    assign w_reject = !f3_legal(bus.req_funct3) ||
                      f3_misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
    assign w_reject = !f3_legal(bus.req_funct3);
`endif

    // Lane addresses only move on a real RAM access, so they hold across idle and rejects.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ready      <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_re         <= 1'b0;
            r_we         <= 1'b0;
            r_drv        <= 1'b0;
            r_funct3     <= F3_W;
            r_lane_addr  <= '0;
            r_lane_wdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_ready  <= 1'b0;
                        r_rdata  <= '0;
                        r_funct3 <= bus.req_funct3;
                        if (w_reject) begin
                            r_err       <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_err        <= 1'b0;
                            r_lane_addr  <= w_lane_addr;
                            r_lane_wdata <= w_lane_wdata;
                            if (bus.req_we) begin
                                r_drv   <= 1'b1;
                                r_state <= S_WR_SETUP;
                            end else begin
                                r_re    <= 1'b1;
                                r_state <= S_RD;
                            end
                        end
                    end
                end
                S_RD: begin
                    r_re        <= 1'b0;
                    r_rdata     <= w_rdata;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_WR_SETUP: begin
                    r_we    <= 1'b1;
                    r_state <= S_WR_STROBE;
                end
                S_WR_STROBE: begin
                    r_we    <= 1'b0;
                    r_state <= S_WR_HOLD;
                end
                S_WR_HOLD: begin
                    r_drv       <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_re    <= 1'b0;
                    r_we    <= 1'b0;
                    r_drv   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_rd_lane = {ram_data3, ram_data2, ram_data1, ram_data0};

    assign ram_data0 = r_drv ? r_lane_wdata[0] : 8'bz;
    assign ram_data1 = r_drv ? r_lane_wdata[1] : 8'bz;
    assign ram_data2 = r_drv ? r_lane_wdata[2] : 8'bz;
    assign ram_data3 = r_drv ? r_lane_wdata[3] : 8'bz;

    assign ram_addr0 = r_lane_addr[0];
    assign ram_addr1 = r_lane_addr[1];
    assign ram_addr2 = r_lane_addr[2];
    assign ram_addr3 = r_lane_addr[3];
    assign ram_re    = r_re;
    assign ram_we    = r_we;

    assign bus.req_ready = r_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;

    assign o_dbg.state    = r_state;
    assign o_dbg.lane_drv = r_drv;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed bench for data_ram_ctrl with a 64-byte behavioural RAM on the lane bus.
module tb_data_ram_ctrl;
    import dram_pkg::*;

    localparam int AW = 6;

    logic clk;
    logic rst;
    data_ram_ctrl_if bus ();

    logic            ram_re;
    logic            ram_we;
    logic [AW-1:0]   ram_addr0, ram_addr1, ram_addr2, ram_addr3;
    wire  [7:0]      ram_data0, ram_data1, ram_data2, ram_data3;
    dram_dbg_t       dbg;

    data_ram_ctrl #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ram_re    (ram_re),
        .ram_we    (ram_we),
        .ram_addr0 (ram_addr0),
        .ram_addr1 (ram_addr1),
        .ram_addr2 (ram_addr2),
        .ram_addr3 (ram_addr3),
        .ram_data0 (ram_data0),
        .ram_data1 (ram_data1),
        .ram_data2 (ram_data2),
        .ram_data3 (ram_data3),
        .o_dbg     (dbg)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural RAM: level read, write on rising ram_we
    logic [7:0] mem [64];
    assign ram_data0 = ram_re ? mem[ram_addr0] : 8'bz;
    assign ram_data1 = ram_re ? mem[ram_addr1] : 8'bz;
    assign ram_data2 = ram_re ? mem[ram_addr2] : 8'bz;
    assign ram_data3 = ram_re ? mem[ram_addr3] : 8'bz;

    always @(posedge ram_we) begin
        mem[ram_addr0] = ram_data0;
        mem[ram_addr1] = ram_data1;
        mem[ram_addr2] = ram_data2;
        mem[ram_addr3] = ram_data3;
    end

    // monitors
    int          we_cnt = 0;
    int          re_cnt = 0;
    int          rsp_cnt = 0;
    int          clash_cnt = 0;
    logic [23:0] we_addrs = '0;
    logic [23:0] re_addrs = '0;

    always @(negedge clk) begin
        if (ram_we) begin
            we_cnt++;
            we_addrs = {ram_addr3, ram_addr2, ram_addr1, ram_addr0};
        end
        if (ram_re) begin
            re_cnt++;
            re_addrs = {ram_addr3, ram_addr2, ram_addr1, ram_addr0};
        end
        if (bus.rsp_valid) rsp_cnt++;
        if (ram_re && dbg.lane_drv) clash_cnt++;
    end

    // checking
    int vec_cnt = 0;
    int miss_cnt = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // driver: returns data, error, latency from accept edge and RAM strobe/read counts
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat, output int we_d, output int re_d);
        int we0;
        int re0;
        @(negedge clk);
        we0 = we_cnt;
        re0 = re_cnt;
        check("req_ready", {31'h0, bus.req_ready}, 32'h1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                lat = c;
                break;
            end
        end
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        @(negedge clk);
        we_d = we_cnt - we0;
        re_d = re_cnt - re0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          wd;
    int          rdn;
    int          rsp0;
    int          guard;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(8'h40 + i);
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'h0, bus.req_ready}, 32'h1);
        check("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        check("rst_rdata", bus.rsp_rdata, 32'h0);
        check("rst_err", {31'h0, bus.rsp_err}, 32'h0);
        check("rst_re_we", {30'h0, ram_re, ram_we}, 32'h0);
        check("rst_addr", {8'h0, ram_addr3, ram_addr2, ram_addr1, ram_addr0}, 32'h0);
        check("rst_drv", {31'h0, dbg.lane_drv}, 32'h0);
        check("rst_state", {29'h0, dbg.state}, {29'h0, S_IDLE});
        rst = 1'b0;

        // SW / LW round trip
        do_req(1'b1, F3_W, 32'd8, 32'hA1B2C3D4, rd, er, lat, wd, rdn);
        check("sw8_lat", lat, 4);
        check("sw8_rdata", rd, 32'h0);
        check("sw8_err", {31'h0, er}, 32'h0);
        check("sw8_we_pulses", wd, 1);
        check("sw8_no_re", rdn, 0);
        check("sw8_addrs", {8'h0, we_addrs}, {8'h0, 6'd11, 6'd10, 6'd9, 6'd8});
        do_req(1'b0, F3_W, 32'd8, 32'h0, rd, er, lat, wd, rdn);
        check("lw8_lat", lat, 2);
        check("lw8_rdata", rd, 32'hA1B2C3D4);
        check("lw8_re_cycles", rdn, 1);
        check("lw8_no_we", wd, 0);

        // SB / LB / LBU and neighbours untouched
        do_req(1'b1, F3_B, 32'd12, 32'h12345680, rd, er, lat, wd, rdn);
        check("sb12_lat", lat, 4);
        check("sb12_addrs", {8'h0, we_addrs}, {8'h0, 6'd12, 6'd12, 6'd12, 6'd12});
        do_req(1'b0, F3_B, 32'd12, 32'h0, rd, er, lat, wd, rdn);
        check("lb12", rd, 32'hFFFFFF80);
        do_req(1'b0, F3_BU, 32'd12, 32'h0, rd, er, lat, wd, rdn);
        check("lbu12", rd, 32'h00000080);
        do_req(1'b0, F3_W, 32'd12, 32'h0, rd, er, lat, wd, rdn);
        check("lw12_neighbours", rd, 32'h4F4E4D80);

        // halfword loads, signed and unsigned
        do_req(1'b0, F3_H, 32'd10, 32'h0, rd, er, lat, wd, rdn);
        check("lh10", rd, 32'hFFFFA1B2);
        do_req(1'b0, F3_HU, 32'd10, 32'h0, rd, er, lat, wd, rdn);
        check("lhu10", rd, 32'h0000A1B2);
        do_req(1'b0, F3_H, 32'd2, 32'h0, rd, er, lat, wd, rdn);
        check("lh2_pos", rd, 32'h00004342);

        // SH at the top of the RAM, then wrapped LW
        do_req(1'b1, F3_H, 32'd62, 32'hDEAD7F01, rd, er, lat, wd, rdn);
        check("sh62_addrs", {8'h0, we_addrs}, {8'h0, 6'd63, 6'd62, 6'd63, 6'd62});
        do_req(1'b0, F3_W, 32'd62, 32'h0, rd, er, lat, wd, rdn);
        check("lw62_rdata", rd, 32'h41407F01);
        check("lw62_addrs", {8'h0, re_addrs}, {8'h0, 6'd1, 6'd0, 6'd63, 6'd62});

        // illegal funct3
        do_req(1'b1, 3'b011, 32'd4, 32'hFFFFFFFF, rd, er, lat, wd, rdn);
        check("bad_f3_lat", lat, 1);
        check("bad_f3_err", {31'h0, er}, 32'h1);
        check("bad_f3_ram_idle", wd + rdn, 0);
        do_req(1'b0, 3'b110, 32'd4, 32'h0, rd, er, lat, wd, rdn);
        check("bad_f3b_err", {31'h0, er}, 32'h1);
        check("bad_f3b_ram_idle", wd + rdn, 0);

        // misaligned word load
        do_req(1'b0, F3_W, 32'd5, 32'h0, rd, er, lat, wd, rdn);
`ifdef DRAM_MISALIGN_TRAP_EN
        check("lw5_err", {31'h0, er}, 32'h1);
        check("lw5_lat", lat, 1);
        check("lw5_no_re", rdn, 0);
`else
        check("lw5_err", {31'h0, er}, 32'h0);
        check("lw5_lat", lat, 2);
        check("lw5_rdata", rd, 32'hD4474645);
`endif

        // reset while the write strobe is high
        @(negedge clk);
        rsp0 = rsp_cnt;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'd20;
        bus.req_wdata  = 32'h55667788;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        guard = 0;
        while (dbg.state != S_WR_STROBE && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("abort_reached_strobe", {29'h0, dbg.state}, {29'h0, S_WR_STROBE});
        rst = 1'b1;
        @(negedge clk);
        check("abort_state", {29'h0, dbg.state}, {29'h0, S_IDLE});
        check("abort_we", {31'h0, ram_we}, 32'h0);
        check("abort_drv", {31'h0, dbg.lane_drv}, 32'h0);
        check("abort_ready", {31'h0, bus.req_ready}, 32'h1);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_no_rsp", rsp_cnt - rsp0, 0);

        // normal service resumes
        do_req(1'b0, F3_W, 32'd8, 32'h0, rd, er, lat, wd, rdn);
        check("post_abort_lw8", rd, 32'hA1B2C3D4);
        check("re_drive_clash", clash_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_ram_ctrl.md
# data_ram_ctrl

Sequencing controller for the 64-byte, four-lane, byte-addressed data RAM used by the RV32 core's memory stage. It accepts one load or store request at a time from the pipeline, derives the four lane addresses, and drives the RAM's level read-enable, edge-triggered write-enable and shared bidirectional data lanes. Load data is returned sign- or zero-extended per RV32I `funct3`. The block sits between the memory stage and the RAM, and is the only master of the RAM's enables.

## Interface
- `ADDR_W`, default 6: RAM byte-address width; addresses wrap modulo 2^ADDR_W.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller is in IDLE and can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `req_addr` in 32: byte address; only `[ADDR_W-1:0]` is used.
- `req_wdata` in 32: store data, little-endian.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data; 0 for stores.
- `rsp_err` out 1: illegal `funct3`, or a trapped misalignment; qualified by `rsp_valid`.
- `ram_re` out 1: RAM read enable (level).
- `ram_we` out 1: RAM write strobe; the RAM writes on its rising edge.
- `ram_addr0`..`ram_addr3` out ADDR_W each: lane byte addresses.
- `ram_data0`..`ram_data3` inout 8 each: lane data; driven by this block only while a store is in progress.

## Operation
- A request is accepted when `req_valid && req_ready`. Fields are registered on acceptance. No new request is taken until `rsp_valid` has fired.
- Lane addresses:
  - Lane i = `addr + i` (mod 2^ADDR_W) for active lanes. Active lanes are B: lane 0; H: lanes 0–1; W: lanes 0–3.
  - Inactive lanes alias an active lane: for H, lane2=lane0 and lane3=lane1; for B, lanes 1–3 = lane 0.
  - During a store, aliased lanes also carry the aliased data, so the RAM's unconditional four-lane write is harmless.
- FSM states: IDLE, RD, WR_SETUP, WR_STROBE, WR_HOLD, RESP.
  - IDLE → RD (load) or WR_SETUP (store) on accept.
  - IDLE → RESP directly on an illegal `funct3`, with `rsp_err`=1 and no RAM activity.
  - RD: `ram_re`=1; lanes captured at the end of the cycle → RESP.
  - WR_SETUP: addresses and data driven, `ram_we`=0 → WR_STROBE.
  - WR_STROBE: `ram_we`=1 → WR_HOLD.
  - WR_HOLD: `ram_we`=0, addresses and data still driven → RESP.
  - RESP: `rsp_valid`=1 → IDLE.
- Load extension:
  - B/H: sign-extend from bit 7/15.
  - BU/HU: zero-extend.
  - W: lanes concatenated as {lane3, lane2, lane1, lane0}.
- `ram_re` and the data-lane drive are never active in the same cycle.
- `ram_addr*` is held at the last value outside active states.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `ram_re`=0, `ram_we`=0, `ram_addr*`=0, data lanes undriven (z), state IDLE.
- Latency is counted from the accept edge (cycle 0):
  - Load: `rsp_valid` in cycle 2.
  - Store: `rsp_valid` in cycle 4.
  - Illegal `funct3`: `rsp_valid` in cycle 1.
- Throughput: back-to-back requests are possible, because `req_ready` returns to 1 in the cycle after RESP.
- `ram_we` is high for exactly one cycle, with at least one cycle of stable address/data before and after it.
- Address wrap: a W access at address 62 uses lanes 62, 63, 0, 1.
- Reset mid-operation: `rst` in any state forces IDLE on the next edge. It also drops `ram_we`/`ram_re` and releases the data lanes. No `rsp_valid` is produced for the aborted request.

## Configuration
- `DRAM_MISALIGN_TRAP_EN` defined: an H/HU request with `addr[0]`≠0, or a W request with `addr[1:0]`≠0, goes IDLE → RESP with `rsp_err`=1 and no RAM access.
- Not defined: misaligned accesses proceed as byte-lane accesses with wrap. `rsp_err` then reflects only an illegal `funct3`.

## Structure
- Package `dram_pkg` holds:
  - `funct3` localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - The FSM state enum.
  - The `ADDR_W` default.
- Sub-module `dram_lane_align`: combinational lane-address/alias generation, store-data steering, and load-data extension. The FSM and the tristate drivers stay in `data_ram_ctrl`.

## Test plan
- SW at 8 with `wdata` 0xA1B2C3D4, then LW at 8 → `rsp_rdata`=0xA1B2C3D4; store `rsp_valid` at cycle 4, load at cycle 2; exactly one `ram_we` pulse.
- SB at 12 with 0x80, then LB at 12 → 0xFFFFFF80; LBU at 12 → 0x00000080; bytes 13–15 unchanged from their prior values.
- SH at 62 with 0x7F01 (no macro), then LW at 62 → low half 0x7F01, with bytes at 0 and 1 unchanged; lane addresses observed as 62, 63, 0, 1.
- `funct3`=011 → `rsp_valid` at cycle 1 with `rsp_err`=1; `ram_we`/`ram_re` never asserted.
- With `DRAM_MISALIGN_TRAP_EN`: LW at 5 → `rsp_err`=1 and no `ram_re`. Without it: LW at 5 returns bytes 5–8.
- `rst` asserted during WR_STROBE → next cycle shows IDLE, `ram_we`=0, lanes z, `req_ready`=1, and no `rsp_valid`.
